// File: rtl/screensaver_pkg.sv
// Shared screen geometry, widths and types for the bouncing-box screensaver.
package screensaver_pkg;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;
   localparam int BOX_WIDTH     = 100;
   localparam int BOX_HEIGHT    = 100;

   localparam int X_W   = $clog2(SCREEN_WIDTH);
   localparam int Y_W   = $clog2(SCREEN_HEIGHT);
   localparam int MAX_X = SCREEN_WIDTH - BOX_WIDTH;
   localparam int MAX_Y = SCREEN_HEIGHT - BOX_HEIGHT;

   typedef logic [2:0] color_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Colour never returns to black: 7 wraps to 1.
   function automatic color_t next_color(input color_t c);
      return (c == 3'd7) ? 3'd1 : c + 3'd1;
   endfunction

endpackage

// File: rtl/axis_bounce.sv
// One axis of the bounce: clamps a signed trajectory into [0, MAX] and reflects velocity on a hit.
module axis_bounce #(
   parameter int W   = 11,
   parameter int MAX = 540
) (
   input  logic signed [W-1:0] pos,
   input  logic signed [W-1:0] v,
   output logic signed [W-1:0] pos_next,
   output logic signed [W-1:0] v_next,
   output logic                hit
);

   localparam logic signed [W-1:0] MAX_S = W'(MAX);

   always_comb begin
      pos_next = pos;
      v_next   = v;
      hit      = 1'b0;
      if (pos[W-1]) begin
         pos_next = '0;
         v_next   = -v;
         hit      = 1'b1;
      end else if (pos >= MAX_S) begin
         // landing exactly on the wall reflects too
         pos_next = MAX_S;
         v_next   = -v;
         hit      = 1'b1;
      end
   end

endmodule

// File: rtl/box_motion.sv
// Per-frame box motion: on each vsync falling edge advance, bounce and recolour the box during blanking.
//   state  | meaning
//   IDLE   | waiting for vsync fall; trajectory registered on an unpaused fall
//   STEP   | clamp/reflect both axes into staging registers
//   COMMIT | load staging into outputs, pulse updated/bounce
module box_motion
   import screensaver_pkg::*;
#(
   parameter int INIT_X  = 50,
   parameter int INIT_Y  = 50,
   parameter int INIT_XV = 2,
   parameter int INIT_YV = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           vsync,
   input  logic           pause,
   output logic [X_W-1:0] box_x,
   output logic [Y_W-1:0] box_y,
   output color_t         color,
   output logic           bounce,
   output logic           updated
);

   localparam int XS  = X_W + 1;
   localparam int YS  = Y_W + 1;
   localparam int AXV = (INIT_XV < 0) ? -INIT_XV : INIT_XV;
   localparam int AYV = (INIT_YV < 0) ? -INIT_YV : INIT_YV;

   if (!(AXV > 0 && AXV < MAX_X && AYV > 0 && AYV < MAX_Y)) begin : g_bad_velocity
      $error("box_motion: initial velocity magnitude out of range");
   end

   state_t state, state_next;
   logic   vsync_q, fall;
   logic   load_traj, load_stage, commit;

   logic signed [XS-1:0] px, xv, tx, sx, sxv, nx, nxv;
   logic signed [YS-1:0] py, yv, ty, sy, syv, ny, nyv;
   logic                 hx, hy, shit;
   color_t               scolor;

   assign fall  = vsync_q & ~vsync;
   assign box_x = px[X_W-1:0];
   assign box_y = py[Y_W-1:0];

   axis_bounce #(.W(XS), .MAX(MAX_X)) u_axis_x (
      .pos(tx), .v(xv), .pos_next(nx), .v_next(nxv), .hit(hx)
   );

   axis_bounce #(.W(YS), .MAX(MAX_Y)) u_axis_y (
      .pos(ty), .v(yv), .pos_next(ny), .v_next(nyv), .hit(hy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // A fall seen in STEP or COMMIT is dropped; legal vsync timing never produces one.
   always_comb begin
      state_next = state;
      load_traj  = 1'b0;
      load_stage = 1'b0;
      commit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall && !pause) begin
               load_traj  = 1'b1;
               state_next = STEP;
            end
         end
         STEP: begin
            load_stage = 1'b1;
            state_next = COMMIT;
         end
         COMMIT: begin
            commit     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         px      <= XS'(INIT_X);
         py      <= YS'(INIT_Y);
         xv      <= XS'(INIT_XV);
         yv      <= YS'(INIT_YV);
         color   <= 3'b111;
         tx      <= '0;
         ty      <= '0;
         sx      <= '0;
         sy      <= '0;
         sxv     <= '0;
         syv     <= '0;
         shit    <= 1'b0;
         scolor  <= 3'b111;
         bounce  <= 1'b0;
         updated <= 1'b0;
      end else begin
         vsync_q <= vsync;
         updated <= commit;
         bounce  <= commit & shit;
         if (load_traj) begin
            tx <= px + xv;
            ty <= py + yv;
         end
         if (load_stage) begin
            sx     <= nx;
            sy     <= ny;
            sxv    <= nxv;
            syv    <= nyv;
            shit   <= hx | hy;
            scolor <= (hx | hy) ? next_color(color) : color;
         end
         if (commit) begin
            px    <= sx;
            py    <= sy;
            xv    <= sxv;
            yv    <= syv;
            color <= scolor;
         end
      end
   end

endmodule

// File: tb/tb_box_motion.sv
// Randomized frame-level bench for box_motion: three instances with different start points against a per-frame model.
module tb_box_motion;
   import screensaver_pkg::*;

   localparam int ND = 3;
   localparam int IX[ND]  = '{50, 538, 1};
   localparam int IY[ND]  = '{50, 377, 0};
   localparam int IXV[ND] = '{2, 2, -2};
   localparam int IYV[ND] = '{1, 1, -1};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic vsync = 1'b1;
   logic pause = 1'b0;

   logic [X_W-1:0] bx [ND];
   logic [Y_W-1:0] by [ND];
   color_t         col [ND];
   logic           bnc [ND];
   logic           upd [ND];

   box_motion u_dut0 (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause),
      .box_x(bx[0]), .box_y(by[0]), .color(col[0]), .bounce(bnc[0]), .updated(upd[0])
   );

   box_motion #(.INIT_X(538), .INIT_Y(377), .INIT_XV(2), .INIT_YV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause),
      .box_x(bx[1]), .box_y(by[1]), .color(col[1]), .bounce(bnc[1]), .updated(upd[1])
   );

   box_motion #(.INIT_X(1), .INIT_Y(0), .INIT_XV(-2), .INIT_YV(-1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause),
      .box_x(bx[2]), .box_y(by[2]), .color(col[2]), .bounce(bnc[2]), .updated(upd[2])
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int mx [ND];
   int my [ND];
   int mvx[ND];
   int mvy[ND];
   int mc [ND];
   int mb [ND];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         mx[d] = IX[d];  my[d] = IY[d];
         mvx[d] = IXV[d]; mvy[d] = IYV[d];
         mc[d] = 7;       mb[d] = 0;
      end
   endtask

   task automatic axis(inout int p, inout int v, input int lim, output int h);
      int t;
      t = p + v;
      if (t < 0)        begin p = 0;   v = -v; h = 1; end
      else if (t >= lim) begin p = lim; v = -v; h = 1; end
      else              begin p = t;   h = 0; end
   endtask

   task automatic model_step();
      int hx, hy;
      for (int d = 0; d < ND; d++) begin
         axis(mx[d], mvx[d], MAX_X, hx);
         axis(my[d], mvy[d], MAX_Y, hy);
         mb[d] = (hx != 0 || hy != 0) ? 1 : 0;
         if (mb[d] != 0) mc[d] = (mc[d] == 7) ? 1 : mc[d] + 1;
      end
   endtask

   task automatic compare_all(input int exp_upd);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("d%0d_box_x", d), int'(bx[d]), mx[d]);
         check($sformatf("d%0d_box_y", d), int'(by[d]), my[d]);
         check($sformatf("d%0d_color", d), int'(col[d]), mc[d]);
         check($sformatf("d%0d_updated", d), int'(upd[d]), exp_upd);
         check($sformatf("d%0d_bounce", d), int'(bnc[d]), exp_upd != 0 ? mb[d] : 0);
      end
   endtask

   // One vsync low pulse; optionally assert reset while the update is in flight.
   task automatic frame(input bit p, input bit do_rst);
      @(negedge clk);
      vsync = 1'b0;
      pause = p;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (do_rst && i == 1) begin
            rst_n = 1'b0;
            vsync = 1'b1;
            #1;
            model_reset();
            compare_all(0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (6) begin @(posedge clk); #1; compare_all(0); end
            return;
         end
         if (i == 3 && !p) model_step();
         compare_all((i == 3 && !p) ? 1 : 0);
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
      vsync = 1'b1;
      repeat ($urandom_range(3, 8)) begin @(posedge clk); #1; compare_all(0); end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      compare_all(0);
      rst_n = 1'b1;
      repeat (5) begin @(posedge clk); #1; compare_all(0); end

      frame(1'b0, 1'b0);
      frame(1'b0, 1'b0);
      repeat (3) frame(1'b1, 1'b0);
      frame(1'b0, 1'b0);
      frame(1'b0, 1'b1);
      frame(1'b0, 1'b0);

      for (int k = 0; k < 400; k++)
         frame($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
